pot_dot_product_sequencer: RTL and testbench



---
 rtl/pot_dot_product_sequencer.sv | 125 ++++++++++++
 tb/tb_pot_dot_product_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_dot_product_sequencer.sv
// Dot-product sequencer: one shared power-of-two shift datapath accumulates
// VECTOR_LENGTH unsigned-by-PoT products and presents the signed sum on a valid/ready port.

module unsigned_pot_shift #(
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int OUTPUT_BIT_WIDTH = 12
) (
  input  logic        [INPUT_BIT_WIDTH-1:0]  data,
  input  logic        [WEIGHT_BIT_WIDTH-1:0] weight,
  output logic signed [OUTPUT_BIT_WIDTH-1:0] product
);

  logic [OUTPUT_BIT_WIDTH-1:0] magnitude_s;

  // Shift the magnitude by the exponent, then apply the weight sign (-0 stays 0).
  always_comb begin
    magnitude_s = OUTPUT_BIT_WIDTH'(data) << weight[WEIGHT_BIT_WIDTH-2:0];
    if (weight[WEIGHT_BIT_WIDTH-1]) begin
      product = -magnitude_s;
    end else begin
      product = magnitude_s;
    end
  end

endmodule

module pot_dot_product_sequencer #(
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int OUTPUT_BIT_WIDTH = 12,
  parameter int VECTOR_LENGTH    = 8,
  parameter int ACC_BIT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic        [INPUT_BIT_WIDTH-1:0]  in_data,
  input  logic        [WEIGHT_BIT_WIDTH-1:0] in_weight,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [ACC_BIT_WIDTH-1:0]    out_result,
  output logic                            busy
);

  localparam int CNT_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                            state_r;
  logic        [CNT_W-1:0]           count_r;
  logic signed [ACC_BIT_WIDTH-1:0]   acc_r;
  logic signed [OUTPUT_BIT_WIDTH-1:0] product_s;
  logic signed [ACC_BIT_WIDTH-1:0]   product_ext_s;
  logic signed [ACC_BIT_WIDTH-1:0]   sum_s;

  unsigned_pot_shift #(
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH),
    .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
    .OUTPUT_BIT_WIDTH(OUTPUT_BIT_WIDTH)
  ) u_shift (
    .data   (in_data),
    .weight (in_weight),
    .product(product_s)
  );

  // Sign-extend the product and form the wrapping running sum.
  always_comb begin
    product_ext_s = ACC_BIT_WIDTH'(product_s);
    sum_s         = acc_r + product_ext_s;
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  // Sequencer FSM: accumulate beats, latch the final sum, hold it until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      count_r    <= '0;
      out_result <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= '0;
            count_r <= '0;
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_r <= sum_s;
            if (count_r == LAST_IDX) begin
              // Count returns to zero so it never exceeds VECTOR_LENGTH-1.
              count_r    <= '0;
              out_result <= sum_s;
              state_r    <= DONE;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pot_dot_product_sequencer.sv
// Bench: default instance (A) and a 12-bit accumulator instance (B) share stimulus and are
// compared every cycle against a queue-based model; a VECTOR_LENGTH=1 instance (C) sweeps all products.

module tb_pot_dot_product_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_data = 4'd0, in_weight = 4'd0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_result;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [11:0] b_out_result;
  logic        c_start = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [3:0]  c_in_data = 4'd0, c_in_weight = 4'd0;
  logic        c_in_ready, c_out_valid, c_busy;
  logic [15:0] c_out_result;

  pot_dot_product_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy));

  pot_dot_product_sequencer #(.ACC_BIT_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .busy(b_busy));

  pot_dot_product_sequencer #(.VECTOR_LENGTH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_weight(c_in_weight), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_result(c_out_result), .busy(c_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pot_value(input logic [3:0] d, input logic [3:0] w);
    longint mag;
    mag = longint'(d) * (longint'(1) << w[2:0]);
    return w[3] ? -mag : mag;
  endfunction

  function automatic logic [31:0] lo(input longint v, input int wd);
    return 32'(v & ((longint'(1) << wd) - 1));
  endfunction

  // Reference model: phase 0 idle, 1 collecting, 2 result held; sum is plain integer arithmetic.
  int     m_phase = 0;
  longint m_items[$];
  longint m_result = 0;
  bit     m_init = 1'b0;

  always @(posedge clk) begin
    m_init = 1'b1;
    if (!rst_n) begin
      m_phase = 0;
      m_items.delete();
      m_result = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_items.delete();
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_items.push_back(pot_value(in_data, in_weight));
        if (m_items.size() == 8) begin
          m_result = 0;
          foreach (m_items[i]) m_result += m_items[i];
          m_phase = 2;
        end
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  // Compare A and B against the model every cycle.
  always @(negedge clk) begin
    if (m_init) begin
      chk("a_in_ready",   32'(in_ready),    32'(m_phase == 1));
      chk("a_busy",       32'(busy),        32'(m_phase != 0));
      chk("a_out_valid",  32'(out_valid),   32'(m_phase == 2));
      chk("a_out_result", 32'(out_result),  lo(m_result, 16));
      chk("b_in_ready",   32'(b_in_ready),  32'(m_phase == 1));
      chk("b_busy",       32'(b_busy),      32'(m_phase != 0));
      chk("b_out_valid",  32'(b_out_valid), 32'(m_phase == 2));
      chk("b_out_result", 32'(b_out_result), lo(m_result, 12));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vd[8];
  logic [3:0] vw[8];

  task automatic run_vector(input bit gaps, input int hold, input bit poke,
                            input logic [15:0] exp_a, input logic [11:0] exp_b);
    int k;
    int lat;
    k = 0;
    lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < 8 && lat < 100) begin
      start = poke && (lat % 3 == 1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 4'hF;
        in_weight = 4'h7;
      end else begin
        in_valid  = 1'b1;
        in_data   = vd[k];
        in_weight = vw[k];
      end
      tick();
      if (in_valid) k++;
      lat++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("beats", 32'(k), 32'd8);
    if (!gaps) chk("latency", 32'(lat + 1), 32'd9);
    chk("vec_out_valid", 32'(out_valid), 32'd1);
    chk("vec_result_a", 32'(out_result), {16'd0, exp_a});
    chk("vec_result_b", 32'(b_out_result), {20'd0, exp_b});
    for (int h = 0; h < hold; h++) begin
      start = poke;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(out_result), {16'd0, exp_a});
    end
    start = poke;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("exit_busy", 32'(busy), 32'd0);
    chk("exit_valid", 32'(out_valid), 32'd0);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with start and in_valid asserted.
    start = 1'b1;
    in_valid = 1'b1;
    c_start = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c_out_result", 32'(c_out_result), 32'd0);
    chk("rst_c_busy", 32'(c_busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    c_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Model pins.
    chk("pin_pot_neg", lo(pot_value(4'd3, 4'b1011), 16), 32'h0000FFE8);
    chk("pin_pot_max", lo(pot_value(4'd15, 4'b0111), 16), 32'd1920);
    chk("pin_pot_negzero", lo(pot_value(4'd0, 4'b1111), 16), 32'd0);

    // Basic vector: +1,+2,+4,+8,-1,-2,-4,-8 times 3 cancels to 0.
    for (int i = 0; i < 8; i++) begin
      vd[i] = 4'd3;
      vw[i] = 4'(((i / 4) << 3) | (i % 4));
    end
    run_vector(1'b0, 0, 1'b0, 16'd0, 12'd0);

    // All-max vector: 15*128*8 = 15360; 12-bit wrap gives 0xC00 (-1024).
    for (int i = 0; i < 8; i++) begin
      vd[i] = 4'd15;
      vw[i] = 4'b0111;
    end
    run_vector(1'b0, 0, 1'b0, 16'd15360, 12'hC00);
    chk("wrap_signed", 32'(signed'(b_out_result)), 32'hFFFFFC00);

    // Mixed vector: 1+4-6+16-5+48-896+512 = -326, with gaps and backpressure.
    vd = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    vw = '{4'b0000, 4'b0001, 4'b1001, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b0110};
    run_vector(1'b1, 5, 1'b0, 16'hFEBA, 12'hEBA);
    run_vector(1'b1, 3, 1'b1, 16'hFEBA, 12'hEBA);

    // Reset after four beats abandons the vector.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd15;
    in_weight = 4'b0111;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vd[i] = 4'd15;
      vw[i] = 4'b0111;
    end
    run_vector(1'b0, 1, 1'b0, 16'd15360, 12'hC00);

    // Exhaustive single-element products.
    for (int d = 0; d < 16; d++) begin
      for (int w = 0; w < 16; w++) begin
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        c_in_valid = 1'b1;
        c_in_data = 4'(d);
        c_in_weight = 4'(w);
        tick();
        c_in_valid = 1'b0;
        chk("c_out_valid", 32'(c_out_valid), 32'd1);
        chk("c_product", 32'(c_out_result), lo(pot_value(4'(d), 4'(w)), 16));
        if (d == 15 && w == 15) chk("c_lit_min", 32'(c_out_result), 32'h0000F880);
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        chk("c_exit_busy", 32'(c_busy), 32'd0);
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
